branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 20 ++
 rtl/branch_predictor_sat_counter2.sv | 29 ++
 rtl/branch_predictor.sv | 112 +++++++++++
 tb/tb_branch_predictor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// ----------------------------------------------------------------------------
// branch_predictor_pkg
// Shared definitions for the bimodal branch predictor: the 2-bit saturating
// counter state encoding and the value every table entry takes on reset.
// No ports (package).
// ----------------------------------------------------------------------------
package branch_predictor_pkg;

    // Bit 1 of the state is the predicted direction (1 = taken).
    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctrState_e;

    // Entries start out predicting taken with full confidence.
    localparam ctrState_e CTR_RESET = STRONG_T;

endpackage : branch_predictor_pkg

// File: rtl/branch_predictor_sat_counter2.sv
// ----------------------------------------------------------------------------
// sat_counter2
// Next-state logic of one 2-bit saturating direction counter.
// Ports:
//   state_i  current counter state
//   taken_i  resolved branch outcome (1 = taken)
//   next_o   counter state after applying the outcome
// ----------------------------------------------------------------------------
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctrState_e state_i,
    input  logic      taken_i,
    output ctrState_e next_o
);

    // Step one state toward the outcome, sticking at either end.
    always_comb begin
        next_o = state_i;
        unique case (state_i)
            STRONG_NT: next_o = taken_i ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   next_o = taken_i ? WEAK_T   : STRONG_NT;
            WEAK_T:    next_o = taken_i ? STRONG_T : WEAK_NT;
            STRONG_T:  next_o = taken_i ? STRONG_T : WEAK_T;
            default:   next_o = state_i;
        endcase
    end

endmodule : sat_counter2

// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
// Bimodal predictor: a flip-flop table of 2**IDX_W 2-bit saturating counters
// indexed by pc[IDX_W+1:2], plus saturating branch/miss statistics counters.
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   lookup_valid_i/pc_i   ID-stage prediction request
//   predict_o             combinational predicted direction (0 when idle)
//   update_valid_i/pc_i   EX-stage resolved branch
//   update_taken_i        actual outcome
//   update_predict_i      prediction that was used for that branch
//   branch_cnt_o          resolved-branch count (registered, saturating)
//   miss_cnt_o            misprediction count (registered, saturating)
// ----------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lookup_valid_i,
    input  logic [31:0]      lookup_pc_i,
    output logic             predict_o,
    input  logic             update_valid_i,
    input  logic [31:0]      update_pc_i,
    input  logic             update_taken_i,
    input  logic             update_predict_i,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ctrState_e        table_q [ENTRIES];
    logic [IDX_W-1:0] lookupIdx;
    logic [IDX_W-1:0] updateIdx;
    ctrState_e        updateNext;
    logic [1:0]       predState;
    logic [CNT_W-1:0] branchCnt_q, branchCnt_d;
    logic [CNT_W-1:0] missCnt_q, missCnt_d;
    logic             unusedPcBits;

    assign lookupIdx = lookup_pc_i[IDX_W+1:2];
    assign updateIdx = update_pc_i[IDX_W+1:2];

    // Byte offset and high PC bits never select an entry.
    assign unusedPcBits = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0],
                            update_pc_i[31:IDX_W+2], update_pc_i[1:0]};

    // The single counter instance feeds both the table write and the bypass.
    sat_counter2 uSatCounter (
        .state_i (table_q[updateIdx]),
        .taken_i (update_taken_i),
        .next_o  (updateNext)
    );

    // A lookup colliding with an in-flight update sees the value being written.
    always_comb begin
        predState = 2'b00;
        if (lookup_valid_i) begin
            if (update_valid_i && (updateIdx == lookupIdx)) begin
                predState = updateNext;
            end else begin
                predState = table_q[lookupIdx];
            end
        end
    end

    assign predict_o = predState[1];

    // Statistics stick at all-ones instead of wrapping.
    always_comb begin
        branchCnt_d = branchCnt_q;
        missCnt_d   = missCnt_q;
        if (update_valid_i) begin
            if (branchCnt_q != CNT_MAX) begin
                branchCnt_d = branchCnt_q + CNT_W'(1);
            end
            if ((update_taken_i != update_predict_i) && (missCnt_q != CNT_MAX)) begin
                missCnt_d = missCnt_q + CNT_W'(1);
            end
        end
    end

    // Reset wins over a same-cycle update, which is simply dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CTR_RESET;
            end
        end else if (update_valid_i) begin
            table_q[updateIdx] <= updateNext;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branchCnt_q <= '0;
            missCnt_q   <= '0;
        end else begin
            branchCnt_q <= branchCnt_d;
            missCnt_q   <= missCnt_d;
        end
    end

    assign branch_cnt_o = branchCnt_q;
    assign miss_cnt_o   = missCnt_q;

endmodule : branch_predictor

// File: tb/tb_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor
// Drives a default-sized predictor and a CNT_W=4 copy with the same inputs
// and compares both against a behavioural model every cycle, plus directed
// scenarios with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lookupValid = 1'b0;
    logic [31:0] lookupPc = '0;
    logic        updateValid = 1'b0;
    logic [31:0] updatePc = '0;
    logic        updateTaken = 1'b0;
    logic        updatePredict = 1'b0;

    logic        predict;
    logic [15:0] branchCnt;
    logic [15:0] missCnt;
    logic        predictSmall;
    logic [3:0]  branchCntSmall;
    logic [3:0]  missCntSmall;

    int checks = 0;
    int errors = 0;

    // Model: counter strength 0..3 per entry, plain event counts.
    int modelCtr [16];
    int modelBranches = 0;
    int modelMisses = 0;
    bit modelValid = 1'b0;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_W(4), .CNT_W(16)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .lookup_valid_i   (lookupValid),
        .lookup_pc_i      (lookupPc),
        .predict_o        (predict),
        .update_valid_i   (updateValid),
        .update_pc_i      (updatePc),
        .update_taken_i   (updateTaken),
        .update_predict_i (updatePredict),
        .branch_cnt_o     (branchCnt),
        .miss_cnt_o       (missCnt)
    );

    branch_predictor #(.IDX_W(4), .CNT_W(4)) dutSmall (
        .clk_i            (clk),
        .rst_i            (rst),
        .lookup_valid_i   (lookupValid),
        .lookup_pc_i      (lookupPc),
        .predict_o        (predictSmall),
        .update_valid_i   (updateValid),
        .update_pc_i      (updatePc),
        .update_taken_i   (updateTaken),
        .update_predict_i (updatePredict),
        .branch_cnt_o     (branchCntSmall),
        .miss_cnt_o       (missCntSmall)
    );

    function automatic int stepCtr(input int c, input bit taken);
        if (taken) return (c >= 3) ? 3 : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    function automatic int satCount(input int n, input int maxVal);
        return (n > maxVal) ? maxVal : n;
    endfunction

    function automatic int expectedPredict();
        int li, ui, c;
        if (!lookupValid) return 0;
        li = int'((lookupPc >> 2) & 32'hF);
        ui = int'((updatePc >> 2) & 32'hF);
        c = modelCtr[li];
        if (updateValid && (li == ui)) c = stepCtr(c, updateTaken);
        return (c >= 2) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model advances on the same edge as the DUT, reading the inputs of the
    // cycle that just ended.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) modelCtr[i] = 3;
            modelBranches = 0;
            modelMisses = 0;
            modelValid = 1'b1;
        end else if (updateValid) begin
            modelCtr[int'((updatePc >> 2) & 32'hF)] =
                stepCtr(modelCtr[int'((updatePc >> 2) & 32'hF)], updateTaken);
            modelBranches++;
            if (updateTaken != updatePredict) modelMisses++;
        end
    end

    // Every cycle after the first reset both instances must match the model.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("predict", int'(predict), expectedPredict());
            checkOutput("branchCnt", int'(branchCnt), satCount(modelBranches, 65535));
            checkOutput("missCnt", int'(missCnt), satCount(modelMisses, 65535));
            checkOutput("predictSmall", int'(predictSmall), expectedPredict());
            checkOutput("branchCntSmall", int'(branchCntSmall), satCount(modelBranches, 15));
            checkOutput("missCntSmall", int'(missCntSmall), satCount(modelMisses, 15));
        end
    end

    // Drive one cycle of inputs just after the edge, return after the
    // following falling edge so outputs are settled for checking.
    task automatic applyStimulus(input bit r, input bit lv, input logic [31:0] lpc,
                                 input bit uv, input logic [31:0] upc,
                                 input bit ut, input bit up);
        @(posedge clk);
        #1;
        rst = r;
        lookupValid = lv;
        lookupPc = lpc;
        updateValid = uv;
        updatePc = upc;
        updateTaken = ut;
        updatePredict = up;
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset, then look up 0x40.
        applyStimulus(1, 1, 32'h40, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h40, 0, 0, 0, 0);
        checkOutput("resetPredict", int'(predict), 1);
        checkOutput("resetBranchCnt", int'(branchCnt), 0);
        checkOutput("resetMissCnt", int'(missCnt), 0);

        // Training: 11 -> 10 -> 01 predicts not-taken.
        applyStimulus(0, 0, 0, 1, 32'h40, 0, 1);
        applyStimulus(0, 0, 0, 1, 32'h40, 0, 1);
        applyStimulus(0, 1, 32'h40, 0, 0, 0, 0);
        checkOutput("trainTwoNt", int'(predict), 0);
        // Third not-taken reaches 00; a taken then only reaches 01.
        applyStimulus(0, 0, 0, 1, 32'h40, 0, 1);
        applyStimulus(0, 1, 32'h40, 0, 0, 0, 0);
        checkOutput("trainStrongNt", int'(predict), 0);
        applyStimulus(0, 0, 0, 1, 32'h40, 1, 0);
        applyStimulus(0, 1, 32'h40, 0, 0, 0, 0);
        checkOutput("trainOneTaken", int'(predict), 0);
        applyStimulus(0, 0, 0, 1, 32'h40, 1, 1);
        applyStimulus(0, 1, 32'h40, 0, 0, 0, 0);
        checkOutput("trainTwoTaken", int'(predict), 1);
        checkOutput("trainMissCnt", int'(missCnt), 4);

        // Bypass: 0x44 to WEAK_T, then same-cycle update and lookup.
        applyStimulus(0, 0, 0, 1, 32'h44, 0, 1);
        applyStimulus(0, 1, 32'h44, 1, 32'h44, 0, 1);
        checkOutput("bypassPredict", int'(predict), 0);

        // Aliasing and byte offset: 0x48, 0x88, 0x4B share index 2.
        applyStimulus(0, 0, 0, 1, 32'h48, 0, 1);
        applyStimulus(0, 0, 0, 1, 32'h48, 0, 1);
        applyStimulus(0, 1, 32'h88, 0, 0, 0, 0);
        checkOutput("aliasPc88", int'(predict), 0);
        applyStimulus(0, 1, 32'h4B, 0, 0, 0, 0);
        checkOutput("aliasPc4B", int'(predict), 0);
        applyStimulus(0, 1, 32'h4C, 0, 0, 0, 0);
        checkOutput("aliasPc4C", int'(predict), 1);

        // Statistics: 5 updates with 2 mismatches, then 15 more.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'h10, 1, 1);
        applyStimulus(0, 0, 0, 1, 32'h14, 0, 1);
        applyStimulus(0, 0, 0, 1, 32'h18, 1, 1);
        applyStimulus(0, 0, 0, 1, 32'h1C, 1, 0);
        applyStimulus(0, 0, 0, 1, 32'h20, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("statBranch5", int'(branchCnt), 5);
        checkOutput("statMiss2", int'(missCnt), 2);
        for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0, 1, 32'h24, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("statBranch20", int'(branchCnt), 20);
        checkOutput("statSmallSat", int'(branchCntSmall), 15);
        checkOutput("statSmallMiss", int'(missCntSmall), 2);

        // Reset together with an update: the update must be dropped.
        applyStimulus(0, 0, 0, 1, 32'h40, 0, 1);
        applyStimulus(0, 0, 0, 1, 32'h40, 0, 1);
        applyStimulus(1, 0, 0, 1, 32'h40, 0, 1);
        applyStimulus(0, 1, 32'h40, 0, 0, 0, 0);
        checkOutput("midResetPredict", int'(predict), 1);
        checkOutput("midResetBranch", int'(branchCnt), 0);

        // Random traffic over a small PC range to force collisions.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 199) == 0),
                          $urandom_range(0, 1),
                          $urandom & 32'hFF,
                          ($urandom_range(0, 9) < 7),
                          $urandom & 32'hFF,
                          $urandom_range(0, 1),
                          $urandom_range(0, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_branch_predictor
